// File: rtl/dm9000a_rx_packet_read_pkg.sv
// Shared DM9000A constants and types for the RX packet drain path.
package dm9000a_rx_packet_read_pkg;

  localparam logic [15:0] REG_MRCMDX       = 16'h00F0;  // read with no pointer advance
  localparam logic [15:0] REG_MRCMD        = 16'h00F2;  // read with pointer advance
  localparam logic [7:0]  RX_STAT_ERR_MASK = 8'hBF;     // every status bit except MF
  localparam logic [7:0]  RDY_EMPTY        = 8'h00;
  localparam logic [7:0]  RDY_PACKET       = 8'h01;

  localparam int LEN_W = 11;
  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PEEK,
    ST_PEEK2,
    ST_CHK_RDY,
    ST_RD_STAT,
    ST_RD_LEN,
    ST_RD_DATA,
    ST_PUSH,
    ST_FRAME_END,
    ST_DONE
  } state_t;

  // Byte count to 16-bit word count, kept in 11-bit arithmetic like the length field.
  function automatic len_t wordsFromLen(input len_t len);
    len_t sum;
    sum = len + len_t'(1);
    return sum >> 1;
  endfunction

endpackage

// File: rtl/dm9000a_rx_packet_read_if.sv
// Request/response bus to the shared DM9000A IOR transaction engine.
interface dm9000a_rx_packet_read_if;

  logic        out_to_Dm9000a_Ior_RunStart;
  logic [15:0] out_to_Dm9000a_Ior_iReg;
  logic        in_from_Dm9000a_Ior_RunEnd;
  logic [15:0] in_from_Dm9000a_Ior_ReturnValue;

  modport master (
    output out_to_Dm9000a_Ior_RunStart,
    output out_to_Dm9000a_Ior_iReg,
    input  in_from_Dm9000a_Ior_RunEnd,
    input  in_from_Dm9000a_Ior_ReturnValue
  );

  modport slave (
    input  out_to_Dm9000a_Ior_RunStart,
    input  out_to_Dm9000a_Ior_iReg,
    output in_from_Dm9000a_Ior_RunEnd,
    output in_from_Dm9000a_Ior_ReturnValue
  );

endinterface

// File: rtl/dm9000a_rx_packet_read_rx_word_hold.sv
// One-entry valid/ready register slice carrying a data word plus frame markers.
module rx_word_hold #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         sValid,
  output logic         sReady,
  input  logic [W-1:0] sData,
  input  logic         sSof,
  input  logic         sEof,
  output logic         mValid,
  input  logic         mReady,
  output logic [W-1:0] mData,
  output logic         mSof,
  output logic         mEof
);

  assign sReady = !mValid || mReady;

  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: the data register is reset too, because every output must read 0 during reset.
    if (!rstN) begin
      mValid <= 1'b0;
      mData  <= '0;
      mSof   <= 1'b0;
      mEof   <= 1'b0;
    end else if (sValid && sReady) begin
      mValid <= 1'b1;
      mData  <= sData;
      mSof   <= sSof;
      mEof   <= sEof;
    end else if (mReady) begin
      mValid <= 1'b0;
    end
  end

endmodule

// File: rtl/dm9000a_rx_packet_read.sv
// Drains every received frame from DM9000A RX SRAM through the IOR engine and
// streams payload words out; one drain run per iRunStart high period.
module dm9000a_rx_packet_read
  import dm9000a_rx_packet_read_pkg::*;
#(
  parameter int MAX_LEN     = 1536,
  parameter bit DROP_ON_ERR = 1'b1
) (
  input  logic                            iDm9000aClk,
  input  logic                            iRunStart,
  input  logic                            iRxEnable,
  dm9000a_rx_packet_read_if.master        ior,
  output logic [15:0]                     oRxData,
  output logic                            oRxValid,
  input  logic                            iRxReady,
  output logic                            oRxSof,
  output logic                            oRxEof,
  output logic [10:0]                     oRxLen,
  output logic                            oRxErr,
  output logic                            oFatal,
  output logic [7:0]                      oFrameCnt,
  output logic                            oRunEnd
);

  localparam len_t MAX_LEN_L = len_t'(MAX_LEN);

  state_t      state;
  logic        iorReq;
  logic [15:0] iorReg;
  logic [7:0]  rdyByte;
  logic        statErr;
  logic        dropFrame;
  logic        firstWord;
  len_t        wordsLeft;

  logic        iorState;
  logic [15:0] stateReg;
  logic        iorDone;
  logic        loadWord;
  logic        holdInReady;
  len_t        rxLen;
  len_t        rxWords;
  logic        lenErr;

  assign ior.out_to_Dm9000a_Ior_RunStart = iorReq;
  assign ior.out_to_Dm9000a_Ior_iReg     = iorReg;

  assign iorDone  = iorReq && ior.in_from_Dm9000a_Ior_RunEnd;
  assign rxLen    = ior.in_from_Dm9000a_Ior_ReturnValue[10:0];
  assign rxWords  = wordsFromLen(rxLen);
  assign lenErr   = (rxLen == '0) || (rxLen > MAX_LEN_L) ||
                    (ior.in_from_Dm9000a_Ior_ReturnValue[15:11] != 5'd0);
  assign loadWord = (state == ST_RD_DATA) && iorDone && !dropFrame && holdInReady;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    iorState = 1'b0;
    stateReg = REG_MRCMD;
    case (state)
      ST_PEEK, ST_PEEK2: begin
        iorState = 1'b1;
        stateReg = REG_MRCMDX;
      end
      ST_RD_STAT, ST_RD_LEN, ST_RD_DATA: iorState = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iDm9000aClk or negedge iRunStart) begin
    if (!iRunStart) begin
      state     <= ST_IDLE;
      iorReq    <= 1'b0;
      iorReg    <= '0;
      rdyByte   <= '0;
      statErr   <= 1'b0;
      dropFrame <= 1'b0;
      firstWord <= 1'b0;
      wordsLeft <= '0;
      oRxLen    <= '0;
      oRxErr    <= 1'b0;
      oFatal    <= 1'b0;
      oFrameCnt <= '0;
      oRunEnd   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; each register takes the value computed from the
      // previous cycle's state, independent of statement order.
      // A request is raised only from a lowered RunStart, which guarantees the one-cycle gap.
      if (iorState && !iorReq) begin
        iorReq <= 1'b1;
        iorReg <= stateReg;
      end
      case (state)
        ST_IDLE: begin
          state   <= iRxEnable ? ST_PEEK : ST_DONE;
          oRunEnd <= !iRxEnable;
        end
        ST_PEEK: if (iorDone) begin
          iorReq <= 1'b0;
          state  <= ST_PEEK2;
        end
        ST_PEEK2: if (iorDone) begin
          iorReq  <= 1'b0;
          rdyByte <= ior.in_from_Dm9000a_Ior_ReturnValue[7:0];
          state   <= ST_CHK_RDY;
        end
        ST_CHK_RDY: begin
          if (rdyByte == RDY_PACKET) begin
            state <= ST_RD_STAT;
          end else begin
            if (rdyByte != RDY_EMPTY) oFatal <= 1'b1;
            oRunEnd <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_RD_STAT: if (iorDone) begin
          iorReq  <= 1'b0;
          statErr <= |(ior.in_from_Dm9000a_Ior_ReturnValue[15:8] & RX_STAT_ERR_MASK);
          state   <= ST_RD_LEN;
        end
        ST_RD_LEN: if (iorDone) begin
          iorReq    <= 1'b0;
          oRxLen    <= rxLen;
          oRxErr    <= statErr || lenErr;
          dropFrame <= DROP_ON_ERR && (statErr || lenErr);
          wordsLeft <= rxWords;
          firstWord <= 1'b1;
          // A zero word count has nothing left in SRAM for this frame.
          state     <= (rxWords == '0) ? ST_FRAME_END : ST_RD_DATA;
        end
        ST_RD_DATA: if (iorDone) begin
          iorReq <= 1'b0;
          state  <= ST_PUSH;
        end
        ST_PUSH: if (dropFrame || (oRxValid && iRxReady)) begin
          wordsLeft <= wordsLeft - len_t'(1);
          firstWord <= 1'b0;
          state     <= (wordsLeft == len_t'(1)) ? ST_FRAME_END : ST_RD_DATA;
        end
        ST_FRAME_END: begin
          if (!dropFrame) oFrameCnt <= oFrameCnt + 8'd1;
          oRxErr    <= 1'b0;
          dropFrame <= 1'b0;
          state     <= ST_PEEK;
        end
        ST_DONE: oRunEnd <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  rx_word_hold #(.W(16)) uHold (
    .clk    (iDm9000aClk),
    .rstN   (iRunStart),
    .sValid (loadWord),
    .sReady (holdInReady),
    .sData  (ior.in_from_Dm9000a_Ior_ReturnValue),
    .sSof   (firstWord),
    .sEof   (wordsLeft == len_t'(1)),
    .mValid (oRxValid),
    .mReady (iRxReady),
    .mData  (oRxData),
    .mSof   (oRxSof),
    .mEof   (oRxEof)
  );

endmodule

// File: tb/tb_dm9000a_rx_packet_read.sv
// Bench for dm9000a_rx_packet_read: DM9000A SRAM + IOR engine model, stream scoreboard.
module tb_dm9000a_rx_packet_read;

  logic        clk;
  logic        iRunStart;
  logic        iRxEnable;
  logic [15:0] oRxData;
  logic        oRxValid;
  logic        iRxReady;
  logic        oRxSof;
  logic        oRxEof;
  logic [10:0] oRxLen;
  logic        oRxErr;
  logic        oFatal;
  logic [7:0]  oFrameCnt;
  logic        oRunEnd;

  dm9000a_rx_packet_read_if iorBus();

  dm9000a_rx_packet_read #(.MAX_LEN(1536), .DROP_ON_ERR(1'b1)) dut (
    .iDm9000aClk (clk),
    .iRunStart   (iRunStart),
    .iRxEnable   (iRxEnable),
    .ior         (iorBus),
    .oRxData     (oRxData),
    .oRxValid    (oRxValid),
    .iRxReady    (iRxReady),
    .oRxSof      (oRxSof),
    .oRxEof      (oRxEof),
    .oRxLen      (oRxLen),
    .oRxErr      (oRxErr),
    .oFatal      (oFatal),
    .oFrameCnt   (oFrameCnt),
    .oRunEnd     (oRunEnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic [10:0] len;
    logic        err;
  } sb_t;

  typedef struct {
    string       name;
    logic [7:0]  rdy;
    logic [7:0]  status;
    logic [15:0] lenWord;
    int          expFrames;
    int          expMrcmd;
    int          expMrcmdx;
    logic        expFatal;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem[$];
  sb_t         sb[$];
  int          mrcmdCnt, mrcmdxCnt, iorReqCnt;
  int          wordsSeen;
  int          stallAt = -1;
  logic        stallDone;
  logic        readyRandom = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Chip SRAM image: {status, ready} word, length word, payload, and so on.
  task automatic addFrame(input logic [7:0] rdy, input logic [7:0] status, input logic [15:0] lenWord);
    logic [10:0] len;
    logic [10:0] words;
    logic        err;
    logic [15:0] d;
    mem.push_back({status, rdy});
    if (rdy == 8'h01) begin
      mem.push_back(lenWord);
      len   = lenWord[10:0];
      words = len + 11'd1;
      words = words >> 1;
      err   = ((status & 8'hBF) != 8'h00) || (len == 11'd0) || (len > 11'd1536) ||
              (lenWord[15:11] != 5'd0);
      for (int i = 0; i < int'(words); i++) begin
        d = 16'($urandom);
        mem.push_back(d);
        if (!err) sb.push_back('{d, (i == 0), (i == int'(words) - 1), len, 1'b0});
      end
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    iRunStart = 1'b0;
    mem.delete();
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic doRun(input int budget);
    int cyc;
    cyc = 0;
    @(negedge clk);
    iRunStart = 1'b1;
    while (!oRunEnd && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("run_end_reached", 64'(oRunEnd), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  // IOR engine + DM9000A RX SRAM read pointer.
  initial begin : ior_engine
    int   rdPtr;
    int   waitCnt;
    int   lat;
    logic prevReq;
    rdPtr = 0; waitCnt = 0; lat = 0; prevReq = 1'b0;
    mrcmdCnt = 0; mrcmdxCnt = 0; iorReqCnt = 0;
    iorBus.in_from_Dm9000a_Ior_RunEnd      = 1'b0;
    iorBus.in_from_Dm9000a_Ior_ReturnValue = '0;
    forever begin
      @(negedge clk);
      if (!iRunStart) begin
        iorBus.in_from_Dm9000a_Ior_RunEnd = 1'b0;
        rdPtr = 0; waitCnt = 0; prevReq = 1'b0;
        mrcmdCnt = 0; mrcmdxCnt = 0; iorReqCnt = 0;
      end else begin
        if (iorBus.out_to_Dm9000a_Ior_RunStart && !prevReq) iorReqCnt++;
        prevReq = iorBus.out_to_Dm9000a_Ior_RunStart;
        if (iorBus.in_from_Dm9000a_Ior_RunEnd) begin
          iorBus.in_from_Dm9000a_Ior_RunEnd = 1'b0;
        end else if (iorBus.out_to_Dm9000a_Ior_RunStart) begin
          if (waitCnt < lat) begin
            waitCnt++;
          end else begin
            check("ior_reg_known", 64'((iorBus.out_to_Dm9000a_Ior_iReg == 16'h00F0) ||
                                      (iorBus.out_to_Dm9000a_Ior_iReg == 16'h00F2)), 64'd1);
            iorBus.in_from_Dm9000a_Ior_ReturnValue = (rdPtr < mem.size()) ? mem[rdPtr] : 16'h0000;
            if (iorBus.out_to_Dm9000a_Ior_iReg == 16'h00F2) begin
              rdPtr++;
              mrcmdCnt++;
            end else begin
              mrcmdxCnt++;
            end
            iorBus.in_from_Dm9000a_Ior_RunEnd = 1'b1;
            waitCnt = 0;
            lat = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  // Stream sink: drives iRxReady, pops the scoreboard on each transfer, checks hold stability.
  initial begin : stream_monitor
    logic        pending;
    logic        newReady;
    logic [17:0] held;
    int          stallLeft;
    int          iorSnap;
    sb_t         exp;
    pending = 1'b0; held = '0; stallLeft = 0; iorSnap = 0;
    iRxReady = 1'b0; wordsSeen = 0; stallDone = 1'b0;
    forever begin
      @(negedge clk);
      if (!iRunStart) begin
        pending = 1'b0; stallLeft = 0; iRxReady = 1'b0; wordsSeen = 0; stallDone = 1'b0;
      end else begin
        if (pending) begin
          check("hold_valid", 64'(oRxValid), 64'd1);
          check("hold_stable", 64'({oRxData, oRxSof, oRxEof}), 64'(held));
        end
        if (stallLeft > 0) begin
          stallLeft--;
          newReady = 1'b0;
          if (stallLeft == 0) check("stall_no_extra_ior", 64'(iorReqCnt), 64'(iorSnap));
        end else if (oRxValid && stallAt >= 0 && wordsSeen == stallAt && !stallDone) begin
          stallDone = 1'b1;
          stallLeft = 19;
          newReady  = 1'b0;
          iorSnap   = iorReqCnt;
        end else begin
          newReady = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        iRxReady = newReady;
        if (oRxValid && newReady) begin
          check("word_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("rx_data", 64'(oRxData), 64'(exp.data));
            check("rx_sof", 64'(oRxSof), 64'(exp.sof));
            check("rx_eof", 64'(oRxEof), 64'(exp.eof));
            check("rx_len", 64'(oRxLen), 64'(exp.len));
            check("rx_err", 64'(oRxErr), 64'(exp.err));
          end
          wordsSeen++;
        end
        pending = oRxValid && !newReady;
        held    = {oRxData, oRxSof, oRxEof};
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[11];
    vecs = '{
      '{"len60",      8'h01, 8'h00, 16'd60,    1, 32,  4, 1'b0},
      '{"len61_odd",  8'h01, 8'h00, 16'd61,    1, 33,  4, 1'b0},
      '{"crc_drop",   8'h01, 8'h02, 16'd64,    0, 34,  4, 1'b0},
      '{"mf_len2",    8'h01, 8'h40, 16'd2,     1, 3,   4, 1'b0},
      '{"len1",       8'h01, 8'h00, 16'd1,     1, 3,   4, 1'b0},
      '{"len_max",    8'h01, 8'h00, 16'd1536,  1, 770, 4, 1'b0},
      '{"len_over",   8'h01, 8'h00, 16'd1537,  0, 771, 4, 1'b0},
      '{"len_zero",   8'h01, 8'h00, 16'd0,     0, 2,   4, 1'b0},
      '{"len_hibits", 8'h01, 8'h00, 16'h0804,  0, 4,   4, 1'b0},
      '{"rdy_fatal",  8'h5A, 8'h00, 16'd0,     0, 0,   2, 1'b1},
      '{"rdy_empty",  8'h00, 8'h00, 16'd0,     0, 0,   2, 1'b0}
    };
    iRunStart = 1'b0;
    iRxEnable = 1'b0;

    // Reset state, then a run with nothing received.
    resetDut();
    check("reset_outputs", 64'({oRxData, oRxValid, oRxSof, oRxEof, oRxLen, oRxErr, oFatal,
                                oFrameCnt, oRunEnd, iorBus.out_to_Dm9000a_Ior_RunStart}), 64'd0);
    iRunStart = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("no_rx_run_end", 64'(oRunEnd), 64'd1);
    repeat (4) @(negedge clk);
    check("no_rx_ior_count", 64'(iorReqCnt), 64'd0);
    check("no_rx_frames", 64'(oFrameCnt), 64'd0);

    // Single-frame vectors with a randomly throttled sink.
    iRxEnable   = 1'b1;
    readyRandom = 1'b1;
    for (int v = 0; v < 11; v++) begin
      resetDut();
      addFrame(vecs[v].rdy, vecs[v].status, vecs[v].lenWord);
      mem.push_back(16'h0000);
      doRun(20000);
      check({vecs[v].name, "_frames"}, 64'(oFrameCnt), 64'(vecs[v].expFrames));
      check({vecs[v].name, "_mrcmd"}, 64'(mrcmdCnt), 64'(vecs[v].expMrcmd));
      check({vecs[v].name, "_mrcmdx"}, 64'(mrcmdxCnt), 64'(vecs[v].expMrcmdx));
      check({vecs[v].name, "_fatal"}, 64'(oFatal), 64'(vecs[v].expFatal));
      check({vecs[v].name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    end

    // Two back-to-back frames.
    resetDut();
    addFrame(8'h01, 8'h00, 16'd61);
    addFrame(8'h01, 8'h00, 16'd64);
    mem.push_back(16'h0000);
    doRun(20000);
    check("b2b_frames", 64'(oFrameCnt), 64'd2);
    check("b2b_mrcmd", 64'(mrcmdCnt), 64'd67);
    check("b2b_mrcmdx", 64'(mrcmdxCnt), 64'd6);
    check("b2b_sb_drained", 64'(sb.size()), 64'd0);

    // Sink stalled 20 cycles mid-frame.
    readyRandom = 1'b0;
    stallAt     = 5;
    resetDut();
    addFrame(8'h01, 8'h00, 16'd64);
    mem.push_back(16'h0000);
    doRun(20000);
    check("stall_happened", 64'(stallDone), 64'd1);
    check("stall_frames", 64'(oFrameCnt), 64'd1);
    check("stall_sb_drained", 64'(sb.size()), 64'd0);
    stallAt = -1;

    // Reset while data words are being read, then a clean restart.
    readyRandom = 1'b1;
    resetDut();
    addFrame(8'h01, 8'h00, 16'd64);
    mem.push_back(16'h0000);
    @(negedge clk);
    iRunStart = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (!(mrcmdCnt >= 6 && iorBus.out_to_Dm9000a_Ior_RunStart) && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      check("mid_reset_reached_data", 64'(cyc < 2000), 64'd1);
    end
    #2;
    iRunStart = 1'b0;
    #1;
    check("mid_reset_outputs", 64'({oRxData, oRxValid, oRxSof, oRxEof, oRxLen, oRxErr, oFatal,
                                    oFrameCnt, oRunEnd, iorBus.out_to_Dm9000a_Ior_RunStart}), 64'd0);
    resetDut();
    addFrame(8'h01, 8'h00, 16'd60);
    mem.push_back(16'h0000);
    doRun(20000);
    check("restart_frames", 64'(oFrameCnt), 64'd1);
    check("restart_mrcmd", 64'(mrcmdCnt), 64'd32);
    check("restart_sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
